// File: rtl/prbs7_checker.sv
// Receive-side checker for x^7+x^3+1 PRBS: self-synchronises, declares lock, counts errors.
// Predictor free-runs once locked so a single line error is counted once, not multiplied.
module prbs7_checker #(
  parameter int LOCK_COUNT  = 14,
  parameter int WINDOW      = 32,
  parameter int LOSS_THRESH = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             bit_in,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  localparam logic [1:0] S_SEED   = 2'd0;
  localparam logic [1:0] S_HUNT   = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  localparam int MW = $clog2(LOCK_COUNT + 1) + 1;
  localparam int WW = $clog2(WINDOW);
  localparam int EW = $clog2(LOSS_THRESH + 1) + 1;

  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [WW-1:0] WIN_LAST   = WW'(WINDOW - 1);
  localparam logic [EW-1:0] LOSS_LIM   = EW'(LOSS_THRESH);

  logic [1:0]       state_q, state_d;
  logic [7:1]       sreg_q, sreg_d;
  logic [2:0]       fill_q, fill_d;
  logic [MW-1:0]    match_q, match_d;
  logic [WW-1:0]    win_cnt_q, win_cnt_d;
  logic [EW-1:0]    win_err_q, win_err_d;
  logic             err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [CNT_W-1:0] bit_count_q, bit_count_d;

  logic             pred;
  logic             err;
  logic [7:1]       sreg_rx;
  logic [EW-1:0]    win_err_nx;

  always_comb begin
    pred        = sreg_q[7] ^ sreg_q[3];
    err         = bit_in != pred;
    sreg_rx     = {sreg_q[6:1], bit_in};
    win_err_nx  = win_err_q + EW'(err);

    state_d     = state_q;
    sreg_d      = sreg_q;
    fill_d      = fill_q;
    match_d     = match_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
    bit_count_d = bit_count_q;

    if (en) begin
      case (state_q)
        S_SEED: begin
          sreg_d = sreg_rx;
          if (fill_q == 3'd6) begin
            state_d = S_HUNT;
            fill_d  = 3'd0;
            match_d = '0;
          end else begin
            fill_d = fill_q + 3'd1;
          end
        end
        S_HUNT: begin
          sreg_d = sreg_rx;
          // An all-zero register is the LFSR lock-up state and never a valid match.
          if (!err && (sreg_rx != '0)) begin
            if (match_q == MATCH_LAST) begin
              state_d   = S_LOCKED;
              match_d   = '0;
              win_cnt_d = '0;
              win_err_d = '0;
            end else begin
              match_d = match_q + MW'(1);
            end
          end else begin
            match_d = '0;
          end
        end
        S_LOCKED: begin
          sreg_d      = {sreg_q[6:1], pred};
          err_pulse_d = err;
          if (err && (err_count_q != '1)) err_count_d = err_count_q + CNT_W'(1);
          if (bit_count_q != '1)          bit_count_d = bit_count_q + CNT_W'(1);
          if (win_err_nx >= LOSS_LIM) begin
            state_d   = S_SEED;
            fill_d    = 3'd0;
            win_cnt_d = '0;
            win_err_d = '0;
          end else if (win_cnt_q == WIN_LAST) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + WW'(1);
            win_err_d = win_err_nx;
          end
        end
        default: state_d = S_SEED;
      endcase
    end

    if (clr) begin
      err_count_d = '0;
      bit_count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_SEED;
      sreg_q      <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
      bit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
      bit_count_q <= bit_count_d;
    end
  end

  assign locked    = (state_q == S_LOCKED);
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign bit_count = bit_count_q;

endmodule

// File: tb/tb_prbs7_checker.sv
// Directed bench for prbs7_checker: lock timing, error counting, loss/relock, en gaps, clr, reset, saturation.
// A second instance with 4-bit counters shares the stimulus to exercise saturation.
module tb_prbs7_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        bit_in;
  logic        clr;
  logic        locked, err_pulse;
  logic [15:0] err_count, bit_count;
  logic        locked_s, err_pulse_s;
  logic [3:0]  err_count_s, bit_count_s;

  logic [7:1]  gen;
  int          n_checks = 0;
  int          n_errors = 0;
  int          pulse_cnt;
  logic        locked_seen;

  always #5 clk = ~clk;

  prbs7_checker #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .bit_in(bit_in), .clr(clr),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .bit_count(bit_count)
  );

  prbs7_checker #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .en(en), .bit_in(bit_in), .clr(clr),
    .locked(locked_s), .err_pulse(err_pulse_s), .err_count(err_count_s), .bit_count(bit_count_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic e, input logic b);
    en     = e;
    bit_in = b;
    @(posedge clk);
    #1;
    if (err_pulse) pulse_cnt++;
    if (locked) locked_seen = 1'b1;
  endtask

  task automatic send(input logic flip);
    logic nb;
    nb  = gen[7] ^ gen[3];
    gen = {gen[6:1], nb};
    step(1'b1, nb ^ flip);
  endtask

  task automatic send_clean(input int n);
    for (int i = 0; i < n; i++) send(1'b0);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    en     = 1'b0;
    bit_in = 1'b0;
    clr    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst         = 1'b0;
    gen         = 7'b0000001;
    pulse_cnt   = 0;
    locked_seen = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] pat;
    int          acc;
    int          cyc;
    logic        e;

    rst = 1'b1; en = 1'b0; bit_in = 1'b0; clr = 1'b0;
    #1;
    check("rst_locked",    locked,    0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_err_count", err_count, 0);
    check("rst_bit_count", bit_count, 0);

    // Clean stream: lock after exactly 21 accepted bits, then 200 error-free locked bits.
    do_reset();
    send_clean(20);
    check("lock_not_at_20", locked, 0);
    send_clean(1);
    check("lock_at_21", locked, 1);
    send_clean(200);
    check("clean_err_count", err_count, 0);
    check("clean_bit_count", bit_count, 200);

    // Single inverted bit: one pulse, one count, no error multiplication.
    pulse_cnt = 0;
    send(1'b1);
    check("single_pulse_now", err_pulse, 1);
    check("single_err_count", err_count, 1);
    send_clean(40);
    check("single_pulse_total", pulse_cnt, 1);
    check("single_err_after", err_count, 1);
    check("single_still_locked", locked, 1);

    // Four errors in one window: loss of lock on the 4th, then relock after 21 bits.
    do_reset();
    send_clean(21);
    send(1'b1); send(1'b0); send(1'b1); send(1'b0); send(1'b1); send(1'b0);
    check("loss_locked_after_3", locked, 1);
    send(1'b1);
    check("loss_locked_after_4", locked, 0);
    check("loss_err_count", err_count, 4);
    send_clean(20);
    check("relock_not_at_20", locked, 0);
    send_clean(1);
    check("relock_at_21", locked, 1);
    check("relock_err_count", err_count, 4);

    // Three errors per window over six windows: never loses lock; small counters saturate.
    do_reset();
    send_clean(21);
    for (int w = 0; w < 6; w++) begin
      for (int p = 0; p < 32; p++) send((p == 2) || (p == 10) || (p == 20));
      if (w == 1) begin
        check("win_err_count_2w", err_count, 6);
        check("win_locked_2w", locked, 1);
      end
    end
    check("win_locked_6w", locked, 1);
    check("win_err_count_6w", err_count, 18);
    check("win_bit_count_6w", bit_count, 192);
    check("sat_err_count", err_count_s, 15);
    check("sat_bit_count", bit_count_s, 15);
    send(1'b1);
    check("sat_err_hold", err_count_s, 15);

    // All-zero stream never locks.
    do_reset();
    for (int i = 0; i < 100; i++) step(1'b1, 1'b0);
    check("zero_never_locked", locked_seen, 0);

    // Gapped en: lock depends on accepted bits, not cycles.
    do_reset();
    pat = 32'b1011_0010_1110_0101_0011_1010_0110_1001;
    acc = 0;
    cyc = 0;
    while (acc < 21 && cyc < 200) begin
      e = pat[cyc % 32];
      if (e) begin
        acc++;
        send(1'b0);
        if (acc == 20) check("gap_not_at_20", locked, 0);
      end else begin
        step(1'b0, cyc[0]);
      end
      cyc++;
    end
    check("gap_accepted", acc, 21);
    check("gap_lock_at_21", locked, 1);
    step(1'b0, 1'b1);
    check("gap_hold_bit_count", bit_count, 0);

    // clr in the same cycle as an error: counters clear, pulse still fires.
    send_clean(5);
    check("clr_pre_bit_count", bit_count, 5);
    clr = 1'b1;
    send(1'b1);
    clr = 1'b0;
    check("clr_err_count", err_count, 0);
    check("clr_bit_count", bit_count, 0);
    check("clr_err_pulse", err_pulse, 1);
    send(1'b0);
    check("clr_pulse_drop", err_pulse, 0);
    check("clr_bit_count_next", bit_count, 1);

    // Asynchronous reset mid-LOCKED clears outputs before the next edge.
    send(1'b1);
    check("arst_pre_pulse", err_pulse, 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_locked",    locked,    0);
    check("arst_err_pulse", err_pulse, 0);
    check("arst_err_count", err_count, 0);
    check("arst_bit_count", bit_count, 0);
    do_reset();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
